smem_request_arbiter: RTL
=========================

Name: smem_request_arbiter

Overview:
- Initiator side of the block-level shared memory scratchpad, one instance per block.
- Accepts load/store requests from THREADS_PER_BLOCK threads using a per-thread 4-phase valid/done handshake.
- Arbitrates round-robin and issues one access at a time onto the scratchpad's single read port and single write port.
- Captures the synchronous read data, which arrives one cycle after issue, and returns it to the requesting thread.

Parameters:
- ADDR_BITS, 8, scratchpad address width
- DATA_BITS, 8, data word width
- THREADS_PER_BLOCK, 4, number of requesting threads (T); the pointer width is clog2(T), minimum 1

Ports:
- clk  input  1  clock; all logic is on the rising edge
- reset  input  1  synchronous, active-high
- req_valid  input  T  per-thread request; held high until the matching rsp_done bit is seen
- req_write  input  T  per-thread op; 1 = store, 0 = load
- req_addr  input  T*ADDR_BITS  per-thread address; thread t occupies bits [t*ADDR_BITS +: ADDR_BITS]
- req_wdata  input  T*DATA_BITS  per-thread store data, packed the same way
- rsp_done  output  T  per-thread completion flag
- rsp_rdata  output  T*DATA_BITS  per-thread load result, registered, held until overwritten by that thread's next load
- busy  output  1  high whenever the state is not IDLE
- mem_read_enable  output  1  to scratchpad read port
- mem_read_addr  output  ADDR_BITS  to scratchpad read port
- mem_read_data  input  DATA_BITS  from scratchpad; valid on the edge after mem_read_enable is sampled
- mem_write_enable  output  1  to scratchpad write port
- mem_write_addr  output  ADDR_BITS  to scratchpad write port
- mem_write_data  output  DATA_BITS  to scratchpad write port

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr = 0; grant register = 0; grant mask = 0.
- All outputs are registered. There is no combinational path from req_* to mem_*.
- Pending mask: pending[t] = req_valid[t] & ~rsp_done[t].
- Arbitration:
  - Performed in IDLE only.
  - Search starts at rr_ptr and wraps modulo T; the first pending thread wins.
  - On grant of thread g, rr_ptr <= (g+1) mod T.
  - T=1 degenerates to always granting thread 0.
- FSM states: IDLE, RD_WAIT, RD_CAPTURE, WR_WAIT.
- IDLE with no pending thread: stay in IDLE, mem enables 0.
- IDLE, grant g is a load:
  - mem_read_enable <= 1, mem_read_addr <= addr[g]; go to RD_WAIT.
- RD_WAIT:
  - mem_read_enable <= 0; go to RD_CAPTURE.
  - The scratchpad latches read_data on this edge.
- RD_CAPTURE:
  - rsp_rdata[g] <= mem_read_data, rsp_done[g] <= 1; go to IDLE.
- IDLE, grant g is a store:
  - mem_write_enable <= 1, mem_write_addr <= addr[g], mem_write_data <= wdata[g]; go to WR_WAIT.
- WR_WAIT:
  - mem_write_enable <= 0, rsp_done[g] <= 1; go to IDLE.
- Latency, counted from the edge that samples pending in IDLE:
  - Load: rsp_done is high after 3 edges.
  - Store: rsp_done is high after 2 edges.
  - Minimum spacing between grants: load 3 cycles, store 2 cycles.
- rsp_done clearing:
  - rsp_done[t] <= 0 on any edge where req_valid[t] is 0.
  - A completion set for t takes priority over this clear on the same edge.
  - A thread with rsp_done high and req_valid high is not pending; it is never re-serviced until it drops req_valid for at least one cycle.
- Request withdrawn mid-flight: the in-flight access completes normally and rsp_done[g] is set. It then clears on the next edge because req_valid is low.
- Request fields (op, addr, wdata) are captured at grant. Changes after grant are ignored.
- Same address read and written back-to-back: the accesses are serialized, so a load granted after a store's WR_WAIT returns the new data.
- Reset asserted mid-operation: everything returns to reset values on that edge. Any in-flight access is abandoned, and no rsp_done is produced for it.
- Address values are not range-checked. Wrap-around is the scratchpad's responsibility.

Optional Feature:
- Macro: SMEM_READ_COALESCE_EN.
- Defined:
  - When a load is granted to thread g, every other pending thread whose op is load and whose addr equals addr[g] is captured into a grant mask at that same edge.
  - In RD_CAPTURE, every thread in the mask receives rsp_rdata <= mem_read_data and rsp_done <= 1 simultaneously.
  - rr_ptr still advances to (g+1) mod T.
  - Stores are never coalesced.
- Undefined: the grant mask is one-hot (g only); behaviour is exactly as described above.

Test Plan:
- Single store then load:
  - Thread 1 stores 0xA5 at address 0x10: mem_write_enable is high for exactly 1 cycle with addr 0x10 and data 0xA5; rsp_done[1] rises 2 edges after request.
  - Thread 1 drops req_valid, then loads 0x10: rsp_rdata[1] = 0xA5 and rsp_done[1] rises 3 edges after request.
- Round-robin fairness:
  - All 4 threads load simultaneously from distinct addresses 0x00–0x03 (preloaded 0x11, 0x22, 0x33, 0x44), with rr_ptr = 0.
  - Grants go in order 0, 1, 2, 3, each 3 cycles apart.
  - Each rsp_rdata matches its address; the next grant starts at thread 0.
- Handshake hold:
  - Thread 2 keeps req_valid high for 20 cycles after rsp_done[2].
  - Exactly one memory access occurs; rsp_done[2] stays high.
  - rsp_done[2] clears 1 edge after req_valid[2] drops.
- Withdrawal:
  - Thread 3 drops req_valid in RD_WAIT.
  - The access completes; rsp_done[3] pulses high for exactly 1 cycle; no re-issue follows.
- Reset mid-load:
  - Assert reset during RD_CAPTURE.
  - The next cycle shows all outputs 0, busy 0, and no rsp_done.
  - After reset is released, a new request is granted starting from thread 0.
- Coalescing (SMEM_READ_COALESCE_EN defined):
  - Threads 0, 2 and 3 load 0x40 (0x5C) simultaneously.
  - Exactly one mem_read_enable pulse occurs; all three get rsp_rdata = 0x5C and rsp_done on the same edge.
  - With the macro undefined, the same stimulus produces three reads.

Source files
------------

// File: rtl/smem_request_arbiter.sv
// smem_request_arbiter: initiator side of the per-block shared-memory
// scratchpad. Threads raise load/store requests. One access at a time is
// issued onto the scratchpad's single read port and single write port.
//
// Handshake (per thread t), 4-phase valid/done:
//   - The thread raises req_valid[t] with req_write/req_addr/req_wdata
//     stable, and holds it until it sees rsp_done[t].
//   - The op, address and data are captured at grant. Later changes are
//     ignored.
//   - rsp_done[t] stays high while req_valid[t] stays high. The thread is
//     not re-serviced until it drops req_valid[t] for at least one cycle.
//   - rsp_done[t] clears on the first edge that samples req_valid[t] low.
//     A completion on that same edge wins over the clear.
//
// Optional build macro: SMEM_READ_COALESCE_EN. When it is defined, a load
// grant also serves every other pending load to the same address, so all of
// those threads complete from one read.
//
// The FSM state is visible as state_q (IDLE / RD_WAIT / RD_CAPTURE /
// WR_WAIT). The busy output mirrors the state being anything other than IDLE.
module smem_request_arbiter #(
  parameter int ADDR_BITS         = 8,
  parameter int DATA_BITS         = 8,
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [THREADS_PER_BLOCK-1:0]           req_valid,
  input  logic [THREADS_PER_BLOCK-1:0]           req_write,
  input  logic [THREADS_PER_BLOCK*ADDR_BITS-1:0] req_addr,
  input  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] req_wdata,
  output logic [THREADS_PER_BLOCK-1:0]           rsp_done,
  output logic [THREADS_PER_BLOCK*DATA_BITS-1:0] rsp_rdata,
  output logic                                   busy,
  output logic                                   mem_read_enable,
  output logic [ADDR_BITS-1:0]                   mem_read_addr,
  input  logic [DATA_BITS-1:0]                   mem_read_data,
  output logic                                   mem_write_enable,
  output logic [ADDR_BITS-1:0]                   mem_write_addr,
  output logic [DATA_BITS-1:0]                   mem_write_data
);

  localparam int T     = THREADS_PER_BLOCK;
  localparam int PTR_W = (T > 1) ? $clog2(T) : 1;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] RD_WAIT    = 2'd1;
  localparam logic [1:0] RD_CAPTURE = 2'd2;
  localparam logic [1:0] WR_WAIT    = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [T-1:0]           grant_mask_q, grant_mask_d;
  logic [T-1:0]           rsp_done_q, rsp_done_d;
  logic [T*DATA_BITS-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                   busy_q, busy_d;
  logic                   mem_read_enable_q, mem_read_enable_d;
  logic [ADDR_BITS-1:0]   mem_read_addr_q, mem_read_addr_d;
  logic                   mem_write_enable_q, mem_write_enable_d;
  logic [ADDR_BITS-1:0]   mem_write_addr_q, mem_write_addr_d;
  logic [DATA_BITS-1:0]   mem_write_data_q, mem_write_data_d;

  // A thread is waiting for service when it asks and has not yet been answered.
  logic [T-1:0]           pending;
  logic                   grant_found;
  logic [PTR_W-1:0]       grant_idx;
  logic                   grant_write;
  logic [ADDR_BITS-1:0]   grant_addr;
  logic [DATA_BITS-1:0]   grant_wdata;
  logic [T-1:0]           grant_onehot;
  logic [T-1:0]           load_mask;

  assign pending     = req_valid & ~rsp_done_q;
  assign grant_write = req_write[grant_idx];
  assign grant_addr  = req_addr[grant_idx*ADDR_BITS +: ADDR_BITS];
  assign grant_wdata = req_wdata[grant_idx*DATA_BITS +: DATA_BITS];

  // Round-robin search: start at rr_ptr, wrap modulo T, first pending thread wins.
  always_comb begin : arb_comb
    logic [PTR_W:0]   cand_w;
    logic [PTR_W-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_w      = '0;
    cand        = '0;
    for (int i = 0; i < T; i++) begin
      cand_w = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand_w >= (PTR_W+1)'(T)) begin
        cand_w = cand_w - (PTR_W+1)'(T);
      end
      cand = cand_w[PTR_W-1:0];
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Build the set of threads a load grant will answer: the winner, plus
  // matching pending loads when coalescing is built in.
  always_comb begin
    grant_onehot            = '0;
    grant_onehot[grant_idx] = 1'b1;
    load_mask               = grant_onehot;
`ifdef SMEM_READ_COALESCE_EN
    for (int t = 0; t < T; t++) begin
      if (pending[t] && !req_write[t] &&
          (req_addr[t*ADDR_BITS +: ADDR_BITS] == grant_addr)) begin
        load_mask[t] = 1'b1;
      end
    end
`else
    load_mask = grant_onehot;
`endif
  end

  // FSM and output next-state: one access in flight, every output registered.
  always_comb begin
    state_d            = state_q;
    rr_ptr_d           = rr_ptr_q;
    grant_mask_d       = grant_mask_q;
    rsp_rdata_d        = rsp_rdata_q;
    mem_read_addr_d    = mem_read_addr_q;
    mem_write_addr_d   = mem_write_addr_q;
    mem_write_data_d   = mem_write_data_q;
    mem_read_enable_d  = 1'b0;
    mem_write_enable_d = 1'b0;
    // Done flags fall as soon as the thread lets go of its request. A
    // completion below overrides this on the same edge.
    rsp_done_d         = rsp_done_q & req_valid;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          if (grant_idx == PTR_W'(T-1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = grant_idx + PTR_W'(1);
          end
          if (grant_write) begin
            grant_mask_d       = grant_onehot;
            mem_write_enable_d = 1'b1;
            mem_write_addr_d   = grant_addr;
            mem_write_data_d   = grant_wdata;
            state_d            = WR_WAIT;
          end else begin
            grant_mask_d      = load_mask;
            mem_read_enable_d = 1'b1;
            mem_read_addr_d   = grant_addr;
            state_d           = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // The scratchpad samples the read on this edge. Its data shows up next cycle.
        state_d = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        for (int t = 0; t < T; t++) begin
          if (grant_mask_q[t]) begin
            rsp_rdata_d[t*DATA_BITS +: DATA_BITS] = mem_read_data;
            rsp_done_d[t]                         = 1'b1;
          end
        end
        state_d = IDLE;
      end
      WR_WAIT: begin
        rsp_done_d = rsp_done_d | grant_mask_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State registers. Synchronous reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= IDLE;
      rr_ptr_q           <= '0;
      grant_mask_q       <= '0;
      rsp_done_q         <= '0;
      rsp_rdata_q        <= '0;
      busy_q             <= 1'b0;
      mem_read_enable_q  <= 1'b0;
      mem_read_addr_q    <= '0;
      mem_write_enable_q <= 1'b0;
      mem_write_addr_q   <= '0;
      mem_write_data_q   <= '0;
    end else begin
      state_q            <= state_d;
      rr_ptr_q           <= rr_ptr_d;
      grant_mask_q       <= grant_mask_d;
      rsp_done_q         <= rsp_done_d;
      rsp_rdata_q        <= rsp_rdata_d;
      busy_q             <= busy_d;
      mem_read_enable_q  <= mem_read_enable_d;
      mem_read_addr_q    <= mem_read_addr_d;
      mem_write_enable_q <= mem_write_enable_d;
      mem_write_addr_q   <= mem_write_addr_d;
      mem_write_data_q   <= mem_write_data_d;
    end
  end

  assign rsp_done         = rsp_done_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign busy             = busy_q;
  assign mem_read_enable  = mem_read_enable_q;
  assign mem_read_addr    = mem_read_addr_q;
  assign mem_write_enable = mem_write_enable_q;
  assign mem_write_addr   = mem_write_addr_q;
  assign mem_write_data   = mem_write_data_q;

endmodule
